// File: rtl/gumnut_div_pkg.sv
// Shared types and helpers for the Gumnut sequential divider.
// Holds the FSM state encoding, the default width and a magnitude helper.
package gumnut_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH = 8;

    // Two's-complement magnitude; the most negative value maps to
    // 2^(W-1), which still fits when read back as unsigned.
    function automatic logic [DIV_WIDTH-1:0] abs_w(
        input logic [DIV_WIDTH-1:0] v
    );
        return v[DIV_WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/div_sub_step.sv
// One restoring shift-subtract iteration (combinational).
// Ports: rem_in/q_in partial state, divisor; rem_out/q_out next state.
module div_sub_step #(
    parameter int W = 8
) (
    input  logic [W:0]   rem_in,
    input  logic [W-1:0] q_in,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_out,
    output logic [W-1:0] q_out
);

    logic [W+1:0] sh;
    logic [W:0]   diff;

    always_comb begin
        // {R,Q} << 1: the quotient MSB moves into the remainder LSB
        sh   = {rem_in, q_in[W-1]};
        diff = sh[W:0] - {1'b0, divisor};
        if (sh >= {2'b00, divisor}) begin
            rem_out = diff;
            q_out   = {q_in[W-2:0], 1'b1};
        end else begin
            rem_out = sh[W:0];
            q_out   = {q_in[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/gumnut_seq_div.sv
// Multi-cycle restoring divider for DIV/MOD beside the Gumnut ALU.
// Ports: clk, rst, start, dividend, divisor, [signed_op] in;
//   busy, done, quotient, remainder, Dz, Ov out.
// Option: define GUMNUT_SIGNED_DIV_EN for signed_op and the FIX state.
module gumnut_seq_div
    import gumnut_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef GUMNUT_SIGNED_DIV_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             Dz,
    output logic             Ov
);

    localparam int CW = $clog2(WIDTH);

    div_state_t     state;
    logic [CW-1:0]  cnt;
    logic [WIDTH:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;
`ifdef GUMNUT_SIGNED_DIV_EN
    logic           neg_q;
    logic           neg_r;
    logic           ovf;
`endif

    div_sub_step #(.W(WIDTH)) u_step (
        .rem_in  (r),
        .q_in    (q),
        .divisor (dvs),
        .rem_out (r_nxt),
        .q_out   (q_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            r         <= '0;
            q         <= '0;
            dvs       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            Dz        <= 1'b0;
            Ov        <= 1'b0;
`ifdef GUMNUT_SIGNED_DIV_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // the cycle done is high still sits in IDLE,
                    // so a start there must not be accepted
                    if (start && !done) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            Dz        <= 1'b1;
                            Ov        <= 1'b0;
                            state     <= DONE;
                        end else begin
                            Dz    <= 1'b0;
                            Ov    <= 1'b0;
                            r     <= '0;
                            cnt   <= CW'(WIDTH - 1);
                            busy  <= 1'b1;
                            state <= RUN;
`ifdef GUMNUT_SIGNED_DIV_EN
                            if (signed_op) begin
                                q     <= abs_w(dividend);
                                dvs   <= abs_w(divisor);
                                neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                                neg_r <= dividend[WIDTH-1];
                                ovf   <= (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                      && (divisor == '1);
                            end else begin
                                q     <= dividend;
                                dvs   <= divisor;
                                neg_q <= 1'b0;
                                neg_r <= 1'b0;
                                ovf   <= 1'b0;
                            end
`else
                            q   <= dividend;
                            dvs <= divisor;
`endif
                        end
                    end
                end
                RUN: begin
                    r <= r_nxt;
                    q <= q_nxt;
                    if (cnt == '0) begin
`ifdef GUMNUT_SIGNED_DIV_EN
                        state <= FIX;
`else
                        quotient  <= q_nxt;
                        remainder <= r_nxt[WIDTH-1:0];
                        busy      <= 1'b0;
                        state     <= DONE;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
`ifdef GUMNUT_SIGNED_DIV_EN
                    quotient  <= neg_q ? -q : q;
                    remainder <= neg_r ? -r[WIDTH-1:0] : r[WIDTH-1:0];
                    Ov        <= ovf;
                    busy      <= 1'b0;
                    state     <= DONE;
`else
                    state <= IDLE;
`endif
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gumnut_seq_div.sv
// Randomized scoreboard bench for gumnut_seq_div.
// Expected results come from plain integer division in the bench.
module tb_gumnut_seq_div;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       sop = 1'b0;
    logic       busy, done, Dz, Ov;
    logic [7:0] quotient, remainder;

    gumnut_seq_div dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef GUMNUT_SIGNED_DIV_EN
        .signed_op (sop),
`endif
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .Dz        (Dz),
        .Ov        (Ov)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer division; acc is the accepting edge index.
    function automatic exp_t model(logic [7:0] a, logic [7:0] b,
                                   logic s, int acc);
        exp_t e;
        int sa, sb_;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (b == 8'd0) begin
            e.q = 8'hFF;
            e.r = a;
            e.dz = 1'b1;
            e.cyc = acc + 1;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
            e.cyc = acc + 9;
        end else begin
            sa = $signed(a);
            sb_ = $signed(b);
            if (sa == -128 && sb_ == -1) begin
                e.q = 8'h80;
                e.r = 8'h00;
                e.ov = 1'b1;
            end else begin
                e.q = 8'(sa / sb_);
                e.r = 8'(sa % sb_);
            end
            e.cyc = acc + 10;
        end
        return e;
    endfunction

    // Monitor: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("Dz", 32'(Dz), 32'(e.dz));
                chk("Ov", 32'(Ov), 32'(e.ov));
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic issue(logic [7:0] a, logic [7:0] b, logic s);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        sop      = s;
        start    = 1'b1;
        sb.push_back(model(a, b, s, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        logic [7:0] a, b;
        logic s;
        int n;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_Dz", 32'(Dz), 32'd0);
        chk("rst_Ov", 32'(Ov), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 200/7 with a busy check mid-run
        issue(8'd200, 8'd7, 1'b0);
        chk("busy_in_run", 32'(busy), 32'd1);
        wait_idle(40);

        // divide by zero
        issue(8'd5, 8'd0, 1'b0);
        wait_idle(40);

        // start held high across done: second op waits one cycle
        @(negedge clk);
        dividend = 8'd255;
        divisor  = 8'd1;
        sop      = 1'b0;
        start    = 1'b1;
        sb.push_back(model(8'd255, 8'd1, 1'b0, cyc + 1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        dividend = 8'd0;
        divisor  = 8'd3;
        sb.push_back(model(8'd0, 8'd3, 1'b0, cyc + 2));
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_idle(40);

        // reset in the middle of RUN
        issue(8'd100, 8'd3, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        sb.delete();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        chk("abort_Dz", 32'(Dz), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);

        // start during RUN with new operands is ignored
        issue(8'd77, 8'd5, 1'b0);
        @(negedge clk);
        dividend = 8'd1;
        divisor  = 8'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dividend = 8'd9;
        divisor  = 8'd0;
        wait_idle(40);

`ifdef GUMNUT_SIGNED_DIV_EN
        issue(8'hF9, 8'd2, 1'b1);
        wait_idle(40);
        issue(8'h80, 8'hFF, 1'b1);
        wait_idle(40);
        issue(8'h85, 8'd0, 1'b1);
        wait_idle(40);
`endif

        // randomized operands
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            s = 1'b0;
`ifdef GUMNUT_SIGNED_DIV_EN
            s = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                a = 8'h80;
                b = 8'hFF;
            end
`endif
            issue(a, b, s);
            wait_idle(40);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule
